// File: rtl/mc_fetch_unit.sv
// mc_fetch_unit: instruction-fetch stage owning PC and IR, with a req/ack
// memory handshake and a timeout that substitutes a NOP and sets a sticky error.
module mc_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [7:0]        imm8,
    output logic              fetch_stall,
    output logic              fetch_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [15:0]       ir_q, ir_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q, req_d, err_q, err_d, inc_q, inc_d;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        inc_d   = inc_q;
        case (state_q)
            IDLE: begin
                if (IRWrite) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    inc_d   = PCWrite;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end else if (pc_load) begin
                    pc_d = pc_target;
                end
            end
            WAIT: begin
                // an ack arriving on the last allowed cycle still counts as a capture
                if (imem_ack || cnt_q == CNT_LAST) begin
                    ir_d    = imem_ack ? imem_rdata : NOP_INSTR;
                    err_d   = err_q | ~imem_ack;
                    req_d   = 1'b0;
                    pc_d    = inc_q ? pc_q + ADDR_W'(1) : pc_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (pc_load) pc_d = pc_target;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            inc_q   <= inc_d;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[15:12];
    assign rd          = ir_q[11:8];
    assign rs          = ir_q[7:4];
    assign rt          = ir_q[3:0];
    assign imm8        = ir_q[7:0];
    assign fetch_stall = (state_q == IDLE && IRWrite) || state_q == WAIT;
    assign fetch_err   = err_q;
endmodule
